synth_slot_sequencer: RTL and testbench

Frame scheduler for the synth engine datapath. On each audio sample tick it walks the shared oscillator/envelope/mixer pipeline through every voice×envelope slot by driving the `xxxx` slot index and the `n_xxxx_zero` frame marker. It then waits out the pipeline latency and issues a one-cycle `sample_valid` strobe when `lsound_out`/`rsound_out` are settled. It sits between the audio-codec sample clock logic and the oscillator/envgen/mixer instances.

---
 rtl/synth_slot_sequencer.sv | 110 +++++++++++
 tb/tb_synth_slot_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/synth_slot_sequencer.sv
// Frame scheduler: walks every voice x envelope slot once per sample tick, waits
// for the shared pipeline to drain, then strobes sample_valid.
module synth_slot_sequencer #(
    parameter int VOICES       = 8,
    parameter int V_ENVS       = 8,
    parameter int V_WIDTH      = 3,
    parameter int E_WIDTH      = 3,
    parameter int FLUSH_CYCLES = 34
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg_N,
    input  logic                       sample_tick,
    input  logic                       enable,
    input  logic                       ovr_clear,
    output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    output logic                       n_xxxx_zero,
    output logic                       busy,
    output logic                       frame_start,
    output logic                       sample_valid,
    output logic                       overrun,
    output logic [15:0]                frame_count
);

    localparam int SW    = V_WIDTH + E_WIDTH;
    localparam int SLOTS = VOICES * V_ENVS;
    localparam int CW    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [SW-1:0] LAST  = SW'(SLOTS - 1);
    localparam logic [CW-1:0] FLAST = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state;
    logic          pending;
    logic [CW-1:0] flush_cnt;
    logic          tick_ok;
    logic          in_frame;
    logic          start_next;

    assign tick_ok    = sample_tick & enable;
    assign in_frame   = (state == RUN) || (state == FLUSH);
    assign start_next = tick_ok | pending;

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state        <= IDLE;
            pending      <= 1'b0;
            flush_cnt    <= '0;
            xxxx         <= '0;
            n_xxxx_zero  <= 1'b0;
            busy         <= 1'b0;
            frame_start  <= 1'b0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= '0;
        end else begin
            // A fresh overrun event beats a simultaneous clear.
            overrun      <= (in_frame & tick_ok & pending) | (overrun & ~ovr_clear);
            n_xxxx_zero  <= 1'b0;
            frame_start  <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_next) begin
                        state       <= RUN;
                        pending     <= 1'b0;
                        busy        <= 1'b1;
                        n_xxxx_zero <= 1'b1;
                        frame_start <= 1'b1;
                        xxxx        <= '0;
                    end
                end
                RUN: begin
                    if (tick_ok) pending <= 1'b1;
                    if (xxxx == LAST) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end else begin
                        xxxx <= xxxx + SW'(1);
                    end
                end
                FLUSH: begin
                    if (tick_ok) pending <= 1'b1;
                    if (flush_cnt == FLAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        sample_valid <= 1'b1;
                        frame_count  <= frame_count + 16'd1;
                        xxxx         <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // A queued or coincident tick chains straight into the next frame.
                    pending <= 1'b0;
                    if (start_next) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        n_xxxx_zero <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synth_slot_sequencer.sv
// Bench for synth_slot_sequencer: per-cycle comparison against a frame-timeline
// model (frame start cycle + pending/overrun flags) under directed and random ticks.
module tb_synth_slot_sequencer;

    localparam int SLOTS = 64;
    localparam int F     = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  xxxx;
    logic        nz, busy, fs, sv, ovr;
    logic [15:0] fcnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mstart = -1;
    bit mpend = 0;
    bit movr = 0;
    int mcount = 0;

    synth_slot_sequencer dut (
        .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .sample_tick(tick),
        .enable(en), .ovr_clear(clr), .xxxx(xxxx), .n_xxxx_zero(nz),
        .busy(busy), .frame_start(fs), .sample_valid(sv), .overrun(ovr),
        .frame_count(fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_done();
        return (mstart >= 0) && (cyc - mstart == SLOTS + F);
    endfunction

    // Check the current cycle, drive this cycle's inputs, advance the model one cycle.
    task automatic step(input bit t, input bit e, input bit c);
        int o;
        int ex;
        bit eb, esv, ovset;
        o   = (mstart >= 0) ? cyc - mstart : -1;
        ex  = (o >= 0 && o < SLOTS) ? o : (o >= SLOTS && o < SLOTS + F) ? SLOTS - 1 : 0;
        eb  = (o >= 0) && (o < SLOTS + F);
        esv = (o == SLOTS + F);
        chk("xxxx", 32'(xxxx), 32'(ex));
        chk("n_xxxx_zero", 32'(nz), 32'(o == 0));
        chk("frame_start", 32'(fs), 32'(o == 0));
        chk("busy", 32'(busy), 32'(eb));
        chk("sample_valid", 32'(sv), 32'(esv));
        chk("overrun", 32'(ovr), 32'(movr));
        chk("frame_count", 32'(fcnt), 32'((mcount + (esv ? 1 : 0)) & 16'hFFFF));
        tick = t; en = e; clr = c;
        ovset = 0;
        if (o < 0) begin
            if ((t && e) || mpend) begin mstart = cyc + 1; mpend = 0; end
        end else if (esv) begin
            mcount = (mcount + 1) & 16'hFFFF;
            mstart = (mpend || (t && e)) ? cyc + 1 : -1;
            mpend  = 0;
        end else if (t && e) begin
            if (mpend) ovset = 1;
            else       mpend = 1;
        end
        movr = ovset | (movr & !c);
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bit found;
        // Reset, then a long idle stretch
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) step(0, $urandom_range(0, 1), 0);

        // Single frame with tick at a known offset
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 110; i++) step(0, 1, 0);

        // Back-to-back: pending tick, then an overrun tick, then clear
        step(1, 1, 0);
        for (int i = 0; i < 39; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(0, 1, 1);
        for (int i = 0; i < 200; i++) step(0, 1, 0);

        // Tick in the DONE cycle chains into the next frame
        step(1, 1, 0);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (model_done()) found = 1;
            else step(0, 1, 0);
        end
        chk("done_bound", 32'(found), 32'd1);
        step(1, 1, 0);
        for (int i = 0; i < 110; i++) step(0, 1, 0);

        // enable gating: ignored ticks, then enable dropped mid-frame
        for (int i = 0; i < 200; i++) step((i % 20) == 0, 0, 0);
        step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 220; i++) step((i % 20) == 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
        for (int i = 0; i < 250; i++) step(0, 1, 0);

        // Reset mid-frame at slot 30
        step(1, 1, 0);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (mstart >= 0 && cyc - mstart == 30) found = 1;
            else step($urandom_range(0, 1), 1, 0);
        end
        chk("slot30_bound", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_xxxx", 32'(xxxx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {29'd0, nz, fs, sv}, 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
        chk("rst_frame_count", 32'(fcnt), 32'd0);
        tick = 0; en = 1; clr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mstart = -1; mpend = 0; movr = 0; mcount = 0;
        for (int i = 0; i < 150; i++) step(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
